// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU with shift-add MUL and restoring DIV.
// The DIV datapath and state exist only when SEQ_ALU_DIV_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module seq_alu #(
  parameter int unsigned WIDTH = `DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned M  = WIDTH - 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StExec = 3'd1;
  localparam logic [2:0] StMul  = 3'd2;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [2:0] StDiv  = 3'd3;
`endif
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpInc = 4'd2;
  localparam logic [3:0] OpDec = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;
  localparam logic [3:0] OpXor = 4'd6;
  localparam logic [3:0] OpNot = 4'd7;
  localparam logic [3:0] OpShl = 4'd8;
  localparam logic [3:0] OpShr = 4'd9;
  localparam logic [3:0] OpAsr = 4'd10;
  localparam logic [3:0] OpRol = 4'd11;
  localparam logic [3:0] OpMul = 4'd12;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OpDiv = 4'd13;
`endif

  logic [2:0]       state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic [4:0]       flags_q;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

  // Single-cycle datapath, evaluated from the captured operands during EXEC.
  logic [SW-1:0]    sh, rot;
  logic [WIDTH-1:0] arith_b, rol_r;
  logic             arith_sub, arith_v;
  logic [WIDTH:0]   arith_w, shl_w, shr_w, asr_w;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_e;

  assign sh        = b_q[SW-1:0];
  assign rot       = (32'(sh) >= WIDTH) ? SW'(32'(sh) - WIDTH) : sh;
  assign arith_b   = (op_q == OpAdd || op_q == OpSub) ? b_q : WIDTH'(1);
  assign arith_sub = (op_q == OpSub || op_q == OpDec);
  assign arith_w   = arith_sub ? ({1'b0, a_q} - {1'b0, arith_b})
                               : ({1'b0, a_q} + {1'b0, arith_b});
  assign arith_v   = arith_sub ? ((a_q[M] ^ arith_b[M]) & (arith_w[M] ^ a_q[M]))
                               : (~(a_q[M] ^ arith_b[M]) & (arith_w[M] ^ a_q[M]));
  // One extra bit on each shifter catches the last bit shifted out.
  assign shl_w     = {1'b0, a_q} << sh;
  assign shr_w     = {a_q, 1'b0} >> sh;
  assign asr_w     = $signed({a_q, 1'b0}) >>> sh;
  assign rol_r     = (a_q << rot) | (a_q >> (WIDTH - 32'(rot)));

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    case (op_q)
      OpAdd, OpSub, OpInc, OpDec: begin
        alu_r = arith_w[WIDTH-1:0];
        alu_c = arith_w[WIDTH];
        alu_v = arith_v;
      end
      OpAnd: alu_r = a_q & b_q;
      OpOr:  alu_r = a_q | b_q;
      OpXor: alu_r = a_q ^ b_q;
      OpNot: alu_r = ~a_q;
      OpShl: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      OpShr: begin
        alu_r = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      OpAsr: begin
        alu_r = asr_w[WIDTH:1];
        alu_c = asr_w[0];
      end
      OpRol:   alu_r = rol_r;
      default: alu_e = 1'b1;
    endcase
  end

  // Shift-add step: {result_hi_q, result_q} is the product/multiplier register.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, result_hi_q} + (result_q[0] ? {1'b0, a_q} : '0);

`ifdef SEQ_ALU_DIV_EN
  // Restoring step: result_hi_q is the partial remainder, result_q the dividend/quotient.
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  assign div_sh   = {result_hi_q, result_q[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_diff = div_sh[WIDTH-1:0] - b_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= opcode;
            cnt_q <= '0;
            if (opcode == OpMul) begin
              result_hi_q <= '0;
              result_q    <= B;
              state_q     <= StMul;
            end
`ifdef SEQ_ALU_DIV_EN
            else if (opcode == OpDiv) begin
              result_hi_q <= '0;
              result_q    <= A;
              state_q     <= StDiv;
            end
`endif
            else begin
              state_q <= StExec;
            end
          end
        end
        StExec: begin
          result_q    <= alu_r;
          result_hi_q <= '0;
          flags_q     <= {alu_e, alu_r[M], alu_v, alu_c, ~alu_e & (alu_r == '0)};
          state_q     <= StDone;
        end
        // WIDTH iteration cycles, then one cycle to settle the flags.
        StMul: begin
          if (cnt_q != CW'(WIDTH)) begin
            result_hi_q <= mul_sum[WIDTH:1];
            result_q    <= {mul_sum[0], result_q[WIDTH-1:1]};
            cnt_q       <= cnt_q + CW'(1);
          end else begin
            flags_q <= {1'b0, result_q[M], 1'b0, |result_hi_q, ~|{result_hi_q, result_q}};
            cnt_q   <= '0;
            state_q <= StDone;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        StDiv: begin
          if (cnt_q != CW'(WIDTH)) begin
            result_hi_q <= div_ge ? div_diff : div_sh[WIDTH-1:0];
            result_q    <= {result_q[WIDTH-2:0], div_ge};
            cnt_q       <= cnt_q + CW'(1);
          end else begin
            flags_q <= {(b_q == '0), result_q[M], 2'b00, ~|{result_hi_q, result_q}};
            cnt_q   <= '0;
            state_q <= StDone;
          end
        end
`endif
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table, randomized ops against an arithmetic model,
// plus stall and mid-operation reset sequences for seq_alu at WIDTH=8.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   opcode = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [4:0]   flags;

  int n_cmp = 0;
  int n_fail = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, wanted finish before time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic [4:0] flags;
    int         lat;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic [4:0] flags;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, want);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, r, amt, hi;
    bit c, v, err, z;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    amt = ub % 8;
    r = 0; hi = 0; c = 0; v = 0; err = 0;
    e.lat = 2;
    case (op)
      4'd0: begin r = ua + ub; c = r > 255; v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin r = ua - ub; c = r < 0;   v = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: begin r = ua + 1;  c = r > 255; v = (sa + 1 > 127); end
      4'd3: begin r = ua - 1;  c = r < 0;   v = (sa - 1 < -128); end
      4'd4: r = ua & ub;
      4'd5: r = ua | ub;
      4'd6: r = ua ^ ub;
      4'd7: r = ~ua;
      4'd8: begin r = ua << amt; c = (amt != 0) && (((ua >> (8 - amt)) & 1) != 0); end
      4'd9: begin r = ua >> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
      4'd10: begin r = sa >>> amt; c = (amt != 0) && (((sa >>> (amt - 1)) & 1) != 0); end
      4'd11: r = (ua << amt) | (ua >> (8 - amt));
      4'd12: begin r = ua * ub; hi = (r >> 8) & 255; c = hi != 0; e.lat = W + 2; end
`ifdef SEQ_ALU_DIV_EN
      4'd13: begin
        e.lat = W + 2;
        if (ub == 0) begin r = 255; hi = ua; err = 1; end
        else begin r = ua / ub; hi = ua % ub; end
      end
`endif
      default: err = 1;
    endcase
    e.res = 8'(r & 255);
    e.hi  = 8'(hi);
    z = !err && (e.res == 0) && (e.hi == 0);
    if (op > 4'd12 && err && ub != 0) e.res = 8'h00;
    e.flags = {err, e.res[7], v, c, z};
    return e;
  endfunction

  // Caller sits at a negedge; returns at a negedge after the output handshake.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output exp_t got);
    int k;
    got = '{8'h00, 8'h00, 5'h00, 0};
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("in_ready wait", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    opcode = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    opcode = 4'($urandom);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
    end
    got.lat = out_valid ? k : -1;
    got.res = result;
    got.hi = result_hi;
    got.flags = flags;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[19];
  exp_t got, want;

  initial begin
    vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 5'b00011, 2};
    vecs[1]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 8'h00, 5'b00100, 2};
    vecs[2]  = '{4'd10, 8'h80, 8'h03, 8'hF0, 8'h00, 5'b01000, 2};
    vecs[3]  = '{4'd12, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b00010, 10};
    vecs[4]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 5'b01100, 2};
    vecs[5]  = '{4'd2,  8'hFF, 8'h00, 8'h00, 8'h00, 5'b00011, 2};
    vecs[6]  = '{4'd3,  8'h00, 8'h00, 8'hFF, 8'h00, 5'b01010, 2};
    vecs[7]  = '{4'd3,  8'h80, 8'h00, 8'h7F, 8'h00, 5'b00100, 2};
    vecs[8]  = '{4'd6,  8'hAA, 8'hAA, 8'h00, 8'h00, 5'b00001, 2};
    vecs[9]  = '{4'd7,  8'h0F, 8'h00, 8'hF0, 8'h00, 5'b01000, 2};
    vecs[10] = '{4'd8,  8'h81, 8'h01, 8'h02, 8'h00, 5'b00010, 2};
    vecs[11] = '{4'd9,  8'h01, 8'h01, 8'h00, 8'h00, 5'b00011, 2};
    vecs[12] = '{4'd11, 8'h81, 8'h01, 8'h03, 8'h00, 5'b00000, 2};
    vecs[13] = '{4'd14, 8'h12, 8'h34, 8'h00, 8'h00, 5'b10000, 2};
    vecs[14] = '{4'd15, 8'hFF, 8'hFF, 8'h00, 8'h00, 5'b10000, 2};
    vecs[15] = '{4'd8,  8'h81, 8'h08, 8'h81, 8'h00, 5'b01000, 2};
    vecs[16] = '{4'd12, 8'h00, 8'h05, 8'h00, 8'h00, 5'b00001, 10};
`ifdef SEQ_ALU_DIV_EN
    vecs[17] = '{4'd13, 8'd100, 8'd7, 8'd14, 8'd2, 5'b00000, 10};
    vecs[18] = '{4'd13, 8'h55, 8'h00, 8'hFF, 8'h55, 5'b11000, 10};
`else
    vecs[17] = '{4'd13, 8'd100, 8'd7, 8'h00, 8'h00, 5'b10000, 2};
    vecs[18] = '{4'd13, 8'h55, 8'h00, 8'h00, 8'h00, 5'b10000, 2};
`endif

    // Reset state
    #3;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset result_hi", 32'(result_hi), 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, got);
      check($sformatf("vec%0d result", i), 32'(got.res), 32'(vecs[i].res));
      check($sformatf("vec%0d result_hi", i), 32'(got.hi), 32'(vecs[i].hi));
      check($sformatf("vec%0d flags", i), 32'(got.flags), 32'(vecs[i].flags));
      check($sformatf("vec%0d latency", i), 32'(got.lat), 32'(vecs[i].lat));
    end

    for (int i = 0; i < 250; i++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
      want = model(op, a, b);
      do_op(op, a, b, got);
      if (got.res !== want.res || got.hi !== want.hi || got.flags !== want.flags
          || got.lat != want.lat) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rand%0d op=%0d a=%02h b=%02h: got %02h/%02h/%05b lat %0d, wanted %02h/%02h/%05b lat %0d",
                 i, op, a, b, got.res, got.hi, got.flags, got.lat,
                 want.res, want.hi, want.flags, want.lat);
      end else begin
        n_cmp++;
      end
    end

    // Hold DONE with out_ready low while a competing request is offered
    in_valid = 1'b1; opcode = 4'd0; A = 8'h02; B = 8'h03;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    check("stall out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; opcode = 4'd12; A = 8'($urandom); B = 8'($urandom);
      @(negedge clk);
      check($sformatf("stall%0d result", k), 32'(result), 32'h05);
      check($sformatf("stall%0d result_hi", k), 32'(result_hi), 32'h00);
      check($sformatf("stall%0d flags", k), 32'(flags), 32'h00);
      check($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("after stall out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("after stall in_ready", 32'(in_ready), 32'd1);

    // Reset four cycles into a multiply
    in_valid = 1'b1; opcode = 4'd12; A = 8'hFF; B = 8'hFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midmul rst out_valid", 32'(out_valid), 32'd0);
    check("midmul rst in_ready", 32'(in_ready), 32'd1);
    check("midmul rst result", 32'(result), 32'd0);
    check("midmul rst result_hi", 32'(result_hi), 32'd0);
    check("midmul rst flags", 32'(flags), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(4'd0, 8'h02, 8'h03, got);
    check("post rst add result", 32'(got.res), 32'h05);
    check("post rst add flags", 32'(got.flags), 32'h00);
    check("post rst add latency", 32'(got.lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
